serial_transmitter: RTL and testbench

- Host-side driver for the board's two-wire load interface (sda + sclk).
- Serialises a DATA_LEN-bit word onto sda, MSB first, and generates sclk from the system clock.
- The remote shift register samples sda on each sclk falling edge and shifts it in at bit 0, so after DATA_LEN falling edges it holds data_in exactly.
- Used by bench/auxiliary FPGA logic to load the flip-bit index and DUT input vector.

---
 rtl/serial_transmitter_pkg.sv | 33 +++
 rtl/sclk_tick_gen.sv | 37 +++
 rtl/serial_transmitter.sv | 101 ++++++++++
 tb/tb_serial_transmitter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_transmitter_pkg.sv
// serial_transmitter_pkg
//   Shared definitions for the two-wire (sda + sclk) load interface driver:
//   the CLOG2 helper macro, the transmitter state encoding and the default
//   word length derived from the DUT input count.
`ifndef SERIAL_TRANSMITTER_PKG_SV
`define SERIAL_TRANSMITTER_PKG_SV

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package serial_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        LOW    = 2'd2,
        FINISH = 2'd3
    } tx_state_t;

    // Number of inputs of the DUT configuration being loaded.
    localparam int unsigned NUM_INS = 8;

    // Word length: flip-bit index bytes plus two bytes of DUT input vector.
    function automatic int unsigned default_data_len(input int unsigned num_ins);
        return (int'(`CLOG2(num_ins)) / 8 + 1 + 2) * 8;
    endfunction

    localparam int unsigned DEFAULT_DATA_LEN = default_data_len(NUM_INS);

endpackage

`endif

// File: rtl/sclk_tick_gen.sv
// sclk_tick_gen
//   Half-period divider for the serial clock. tick asserts on the CLK_DIV-th
//   enabled cycle after clear, then the count restarts.
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-low reset
//     clear  in   synchronous restart of the count
//     en     in   count enable
//     tick   out  end of the current half-period (combinational)
module sclk_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int unsigned DIV_W = `CLOG2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    assign tick = en && (div_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (clear) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= tick ? '0 : div_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Host-side driver for the two-wire load interface. Shifts a DATA_LEN-bit
//   word out on sda MSB first; the remote register samples sda on each sclk
//   falling edge.
//   Ports:
//     clk      in   system clock
//     reset    in   asynchronous active-low reset
//     start    in   transfer request, sampled only in IDLE
//     data_in  in   word to send, captured when start is accepted
//     busy     out  transfer in progress
//     done     out  one-cycle pulse after a transfer completes
//     sda      out  serial data (registered)
//     sclk     out  serial clock (registered, idles high)
module serial_transmitter
    import serial_transmitter_pkg::*;
#(
    parameter int unsigned DATA_LEN = DEFAULT_DATA_LEN,
    parameter int unsigned CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [DATA_LEN-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic                sda,
    output logic                sclk
);

    localparam int unsigned BIT_W = `CLOG2(DATA_LEN + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_LEN - 1);

    tx_state_t           state;
    tx_state_t           state_next;
    logic [DATA_LEN-1:0] shift_q;
    logic [BIT_W-1:0]    bit_cnt;
    logic                tick;
    logic                in_xfer;

    assign in_xfer = (state == SETUP) || (state == LOW);

    sclk_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .en    (in_xfer),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   if (tick)  state_next = LOW;
            LOW:     if (tick)  state_next = (bit_cnt != '0) ? SETUP : FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && start) begin
            shift_q <= data_in;
            bit_cnt <= LAST_BIT;
        end else if (state == LOW && tick && bit_cnt != '0) begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - 1'b1;
        end
    end

    // Pins are registered decodes of the current state, so every pin trails
    // the state register by one cycle; sda and sclk therefore always change
    // on the same edge and sda only moves while sclk goes/stays high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            done <= '0;
            sda  <= '0;
            sclk <= '1;
        end else begin
            busy <= in_xfer;
            done <= (state == FINISH);
            sda  <= in_xfer && shift_q[DATA_LEN-1];
            sclk <= (state != LOW);
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter
//   Directed bench for serial_transmitter: a 24-bit / CLK_DIV=4 instance and
//   an 8-bit / CLK_DIV=1 instance, each with a receiver model that shifts sda
//   in at bit 0 on every sclk falling edge.
module tb_serial_transmitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [23:0] data_a;
    logic [7:0]  data_b;
    logic        busy_a, done_a, sda_a, sclk_a;
    logic        busy_b, done_b, sda_b, sclk_b;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_transmitter #(.DATA_LEN(24), .CLK_DIV(4)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .start   (start_a),
        .data_in (data_a),
        .busy    (busy_a),
        .done    (done_a),
        .sda     (sda_a),
        .sclk    (sclk_a)
    );

    serial_transmitter #(.DATA_LEN(8), .CLK_DIV(1)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .start   (start_b),
        .data_in (data_b),
        .busy    (busy_b),
        .done    (done_b),
        .sda     (sda_b),
        .sclk    (sclk_b)
    );

    // Receiver models, reset alongside the transmitters.
    logic [23:0] rx_a;
    logic [7:0]  rx_b;
    int          falls_a = 0;
    int          falls_b = 0;

    always @(negedge sclk_a or negedge reset) begin
        if (!reset) rx_a <= '0;
        else begin
            rx_a    <= {rx_a[22:0], sda_a};
            falls_a <= falls_a + 1;
        end
    end

    always @(negedge sclk_b or negedge reset) begin
        if (!reset) rx_b <= '0;
        else begin
            rx_b    <= {rx_b[6:0], sda_b};
            falls_b <= falls_b + 1;
        end
    end

    // Cycle monitors sampled on the falling clk edge.
    int   busy_cyc_a = 0, done_cyc_a = 0, done_after_busy_a = 0;
    int   busy_cyc_b = 0, low_cyc_b = 0;
    logic busy_prev_a = 1'b0, sda_prev_a = 1'b0, sclk_prev_a = 1'b1;
    int   run_a = 0, since_fall_a = 100, viol_a = 0;

    always @(negedge clk) begin
        busy_cyc_a <= busy_cyc_a + (busy_a ? 1 : 0);
        done_cyc_a <= done_cyc_a + (done_a ? 1 : 0);
        if (done_a && busy_prev_a && !busy_a) done_after_busy_a <= done_after_busy_a + 1;
        busy_prev_a <= busy_a;
        busy_cyc_b  <= busy_cyc_b + (busy_b ? 1 : 0);
        low_cyc_b   <= low_cyc_b + ((busy_b && !sclk_b) ? 1 : 0);

        // sda must change only with sclk high and at least 4 cycles after a fall;
        // at a fall it must have been stable for at least 4 cycles.
        if (sda_a != sda_prev_a) begin
            if (!sclk_a || since_fall_a < 4) viol_a <= viol_a + 1;
            run_a <= 1;
        end else begin
            run_a <= run_a + 1;
        end
        if (sclk_prev_a && !sclk_a) begin
            if (run_a < 4) viol_a <= viol_a + 1;
            since_fall_a <= 1;
        end else if (since_fall_a < 100) begin
            since_fall_a <= since_fall_a + 1;
        end
        sda_prev_a  <= sda_a;
        sclk_prev_a <= sclk_a;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transfer with a one-cycle start. first_fall is the number of clk
    // cycles after the accepting edge at which sclk is first seen low.
    // poke_at >= 2 pulses start_a with poke_d mid-transfer.
    task automatic xfer(input bit use_b, input logic [23:0] d, input int poke_at,
                        input logic [23:0] poke_d, output int first_fall, output bit got_done);
        logic sclk_now;
        @(negedge clk);
        if (use_b) begin
            data_b  = d[7:0];
            start_b = 1'b1;
        end else begin
            data_a  = d;
            start_a = 1'b1;
        end
        first_fall = -1;
        got_done   = 1'b0;
        for (int j = 0; j < 1000 && !got_done; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (j == poke_at) begin
                data_a  = poke_d;
                start_a = 1'b1;
            end else if (j == poke_at + 1) begin
                start_a = 1'b0;
            end
            sclk_now = use_b ? sclk_b : sclk_a;
            if (first_fall < 0 && !sclk_now) first_fall = j;
            if (use_b ? done_b : done_a) got_done = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ff, gap, f0, b0, d0, da0, v0, l0;
        bit ok;

        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_a_sclk", sclk_a, 1);
        check("rst_a_sda",  sda_a,  0);
        check("rst_a_busy", busy_a, 0);
        check("rst_a_done", done_a, 0);
        check("rst_b_sclk", sclk_b, 1);
        check("rst_b_busy", busy_b, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic transfer.
        f0 = falls_a; b0 = busy_cyc_a; d0 = done_cyc_a; da0 = done_after_busy_a; v0 = viol_a;
        xfer(1'b0, 24'hA5C3F0, -1, '0, ff, ok);
        check("t1_done_seen", ok, 1);
        check("t1_rx", rx_a, 32'hA5C3F0);
        check("t1_falls", falls_a - f0, 24);
        check("t1_first_fall", ff, 5);
        @(negedge clk);
        check("t1_busy_cycles", busy_cyc_a - b0, 192);
        check("t1_done_cycles", done_cyc_a - d0, 1);
        check("t1_done_after_busy", done_after_busy_a - da0, 1);
        check("t1_setup_hold", viol_a - v0, 0);
        check("t1_idle_sclk", sclk_a, 1);

        // Reset in the middle of a transfer.
        repeat (3) @(negedge clk);
        f0 = falls_a;
        data_a  = 24'hFFFFFF;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int j = 0; j < 500 && (falls_a - f0) < 10; j++) @(negedge clk);
        check("t3_ten_falls", falls_a - f0, 10);
        #1 reset = 1'b0;
        #1;
        check("t3_rst_sclk", sclk_a, 1);
        check("t3_rst_sda",  sda_a,  0);
        check("t3_rst_busy", busy_a, 0);
        check("t3_rst_done", done_a, 0);
        check("t3_rst_rx",   rx_a,   0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        f0 = falls_a;
        xfer(1'b0, 24'h000001, -1, '0, ff, ok);
        check("t3_done_seen", ok, 1);
        check("t3_rx", rx_a, 32'h000001);
        check("t3_falls", falls_a - f0, 24);

        // start pulsed while busy is ignored.
        repeat (3) @(negedge clk);
        f0 = falls_a; d0 = done_cyc_a;
        xfer(1'b0, 24'h654321, 40, 24'h123456, ff, ok);
        check("t4_done_seen", ok, 1);
        check("t4_rx", rx_a, 32'h654321);
        check("t4_falls", falls_a - f0, 24);
        b0 = busy_cyc_a;
        repeat (100) @(negedge clk);
        check("t4_no_restart", busy_cyc_a - b0, 0);
        check("t4_done_cycles", done_cyc_a - d0, 1);

        // start held high: back-to-back transfers.
        @(negedge clk);
        data_a  = 24'h0F0F0F;
        start_a = 1'b1;
        ok = 1'b0;
        for (int j = 0; j < 400 && !ok; j++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        check("t5_done1_seen", ok, 1);
        check("t5_rx1", rx_a, 32'h0F0F0F);
        data_a = 24'hF0F0F0;
        gap = (!busy_a && sclk_a) ? 1 : 0;
        for (int j = 0; j < 10 && !busy_a; j++) begin
            @(negedge clk);
            if (!busy_a && sclk_a) gap++;
        end
        check("t5_gap", gap, 2);
        ok = 1'b0;
        for (int j = 0; j < 400 && !ok; j++) begin
            @(negedge clk);
            if (done_a) ok = 1'b1;
        end
        start_a = 1'b0;
        check("t5_done2_seen", ok, 1);
        check("t5_rx2", rx_a, 32'hF0F0F0);
        b0 = busy_cyc_a;
        repeat (60) @(negedge clk);
        check("t5_no_third", busy_cyc_a - b0, 0);

        // Minimum divider, short word.
        f0 = falls_b; b0 = busy_cyc_b; l0 = low_cyc_b;
        xfer(1'b1, 24'h000081, -1, '0, ff, ok);
        @(negedge clk);
        check("t6_done_seen", ok, 1);
        check("t6_rx", rx_b, 32'h81);
        check("t6_falls", falls_b - f0, 8);
        check("t6_busy_cycles", busy_cyc_b - b0, 16);
        check("t6_low_cycles", low_cyc_b - l0, 8);
        check("t6_first_fall", ff, 2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
